ro_cache_flush_ctrl: RTL and testbench
======================================

# ro_cache_flush_ctrl

Sequencer for the read-only caches embedded in the hierarchical AXI interconnect tree. It owns the `ro_cache_ctrl_t` bundle fanned out to every cache instance and serialises enable, flush and address-rule updates. It uses the per-cache `flush_ready` handshake so that no cache ever serves stale lines or runs under half-applied address rules. It sits between the control-register file and the interconnect.

## Interface
- `NumCaches`, default 4: number of cache instances driven; must be at least 1.
- `NrAddrRules`, default `mempool_pkg::ROCacheNumAddrRules`: number of cacheable address windows.
- `AddrWidth`, default 32: address width of the rule bounds.
- `TimeoutCycles`, default 1024: watchdog limit. Used only under the macro described in Configuration.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: synchronous active-high reset.
- `enable_i` input, 1 bit: software cache-enable level.
- `flush_req_i` input, 1 bit: single-cycle flush request.
- `cfg_valid_i` input, 1 bit: new address rules are offered.
- `cfg_ready_o` output, 1 bit: rules accepted into the shadow register.
- `start_addr_i` input, NrAddrRules×AddrWidth: new rule start addresses.
- `end_addr_i` input, NrAddrRules×AddrWidth: new rule end addresses.
- `busy_o` output, 1 bit: a sequence is in progress.
- `flush_done_o` output, 1 bit: single-cycle pulse when a sequence completes.
- `ro_cache_ctrl_o` output, NumCaches×`ro_cache_ctrl_t`: per-cache control bundle.
- `flush_ready_i` input, NumCaches bits: per-cache flush acknowledge.
- `timeout_o` output, 1 bit: sticky watchdog error; present only under the macro.

## Operation
- The FSM has three states: IDLE, FLUSH and UPDATE.
- IDLE:
  - `.enable = enable_q` for every cache.
  - `flush_valid` is 0.
  - `cfg_ready_o` is 1.
  - Entry to FLUSH happens when `flush_req_i`, a `cfg_valid_i` handshake, or the pending bit is set.
  - A cfg handshake copies the inputs into the shadow rules and sets `upd_pend`.
- FLUSH:
  - `.enable` is 0 for all caches.
  - `flush_valid[i]` is high while `ack_mask[i]` is 0.
  - A cache handshake completes on `flush_valid[i] & flush_ready_i[i]`. This sets `ack_mask[i]`, and `flush_valid[i]` drops the next cycle.
  - When every bit of `ack_mask` is set, the FSM moves to UPDATE.
- UPDATE lasts exactly one cycle:
  - If `upd_pend`, copy the shadow rules to `.start_addr`/`.end_addr`.
  - Clear `upd_pend` and `ack_mask`.
  - Pulse `flush_done_o`.
  - Return to IDLE.
- Pending requests:
  - `flush_req_i` or a cfg handshake arriving outside IDLE sets `pend`. `pend` holds one level; further requests merge into it.
  - On return to IDLE with `pend` set, the FSM re-enters FLUSH on the next cycle and clears `pend`.
- `cfg_ready_o` is 1 in every state except when `upd_pend` is already set.
- `enable_q` registers `enable_i` every cycle. Deasserting enable does not require a flush.
- `busy_o` is 1 whenever the state is not IDLE or `pend` is set.

## Timing
- Reset values: state IDLE, all `ro_cache_ctrl_o` fields 0, `enable_q` 0, `cfg_ready_o` 1, `busy_o` 0, `flush_done_o` 0, masks and pending bits 0, `timeout_o` 0.
- `flush_req_i` at cycle 0: FLUSH begins at cycle 1, with `flush_valid` high and `.enable` low.
- If all caches are ready at cycle 1: UPDATE at cycle 2 with the `flush_done_o` pulse; new rules and `.enable` are visible at cycle 3. The minimum sequence length is 3 cycles.
- A cache that is ready before the others keeps its `flush_valid` low afterwards. A late cache alone extends FLUSH.
- `flush_req_i` and `cfg_valid_i` in the same IDLE cycle produce one combined sequence.
- Reset in mid-FLUSH aborts the sequence. Outputs return to reset values the next cycle, and the shadow rules are discarded.

## Configuration
- Macro `RO_CACHE_FLUSH_TIMEOUT_EN`.
- When defined:
  - A counter of width `$clog2(TimeoutCycles+1)` runs during FLUSH.
  - When the count reaches `TimeoutCycles`, the FSM forces UPDATE and sets the sticky `timeout_o`.
  - The rules are applied anyway.
  - `timeout_o` clears only on reset.
- When not defined: no counter and no `timeout_o` port. FLUSH waits indefinitely.

## Structure
- `mempool_pkg` holds:
  - the existing `ro_cache_ctrl_t`;
  - the existing `ROCacheNumAddrRules`;
  - a new enum `ro_flush_state_e` for the FSM states.
- Sub-module: one instance of `ro_flush_ack_tracker`, which holds the per-cache ack mask and provides the all-acked reduction.

## Test plan
- **Basic flush:** reset, `enable_i`=1, `flush_req_i` pulse, all `flush_ready_i`=1 → `.enable` 0 in cycles 1–2, `flush_done_o` at cycle 2, `.enable` 1 at cycle 3.
- **Staggered acks:** `NumCaches`=4, caches ready at +1, +3, +5 and +8 cycles → each `flush_valid[i]` drops the cycle after its own ack; `flush_done_o` one cycle after the last ack.
- **Rule update:** cfg handshake with start `0x8000_0000`, end `0x8001_0000` → outputs keep the old rules until UPDATE and show the new values the cycle after.
- **Merge and pend:** `flush_req_i` during FLUSH, plus two further pulses → exactly one extra sequence, so `flush_done_o` pulses twice in total; `busy_o` stays high throughout.
- **Reset mid-flush:** assert `rst_i` while 2 of 4 caches are acked → all outputs 0 the next cycle; no `flush_done_o`.
- **Timeout (macro on):** `TimeoutCycles`=16 and one cache never ready → UPDATE after 16 FLUSH cycles, `timeout_o`=1 and sticky, rules applied.

Source files
------------

// File: rtl/mempool_pkg.sv
// Shared MemPool types: read-only cache control bundle, rule count and
// the flush sequencer state encoding.
package mempool_pkg;

  localparam int unsigned ROCacheNumAddrRules = 2;
  localparam int unsigned ROCacheAddrWidth    = 32;

  typedef struct packed {
    logic                                                  enable;
    logic                                                  flush_valid;
    logic [ROCacheNumAddrRules-1:0][ROCacheAddrWidth-1:0] start_addr;
    logic [ROCacheNumAddrRules-1:0][ROCacheAddrWidth-1:0] end_addr;
  } ro_cache_ctrl_t;

  typedef enum logic [1:0] {
    RoFlushIdle   = 2'd0,
    RoFlushFlush  = 2'd1,
    RoFlushUpdate = 2'd2
  } ro_flush_state_e;

endpackage

// File: rtl/ro_flush_ack_tracker.sv
// Per-cache flush acknowledge mask; reports when every cache has been
// acknowledged, including acks landing in the current cycle.
module ro_flush_ack_tracker #(
  parameter int unsigned NumCaches = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 clear,
  input  logic [NumCaches-1:0] ready,
  output logic [NumCaches-1:0] valid,
  output logic                 all_acked
);

  logic [NumCaches-1:0] ack_mask_q;
  logic [NumCaches-1:0] ack_mask_d;

  assign valid      = active ? ~ack_mask_q : '0;
  assign ack_mask_d = ack_mask_q | (valid & ready);
  assign all_acked  = &ack_mask_d;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ack_mask_q <= '0;
    end else if (active) begin
      ack_mask_q <= ack_mask_d;
    end
  end

endmodule

// File: rtl/ro_cache_flush_ctrl.sv
// Serialises enable, flush and address-rule updates for the read-only caches.
// Optional watchdog on the flush handshake: define RO_CACHE_FLUSH_TIMEOUT_EN.
module ro_cache_flush_ctrl
  import mempool_pkg::*;
#(
  parameter int unsigned NumCaches     = 4,
  parameter int unsigned NrAddrRules   = ROCacheNumAddrRules,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enable_i,
  input  logic                                  flush_req_i,
  input  logic                                  cfg_valid_i,
  output logic                                  cfg_ready_o,
  input  logic [NrAddrRules-1:0][AddrWidth-1:0] start_addr_i,
  input  logic [NrAddrRules-1:0][AddrWidth-1:0] end_addr_i,
  output logic                                  busy_o,
  output logic                                  flush_done_o,
  output ro_cache_ctrl_t [NumCaches-1:0]        ro_cache_ctrl_o,
  input  logic [NumCaches-1:0]                  flush_ready_i
`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
  ,
  output logic                                  timeout_o
`endif
);

  ro_flush_state_e state_q, state_d;
  logic pend_q, pend_d;
  logic upd_pend_q;
  logic enable_q;
  logic cfg_hs, req;
  logic all_acked, timeout_hit;
  logic [NumCaches-1:0] flush_valid;
  logic [NrAddrRules-1:0][AddrWidth-1:0] shadow_start_q, shadow_end_q;
  logic [NrAddrRules-1:0][AddrWidth-1:0] start_q, end_q;

  assign cfg_ready_o  = ~upd_pend_q;
  assign cfg_hs       = cfg_valid_i & cfg_ready_o;
  assign req          = flush_req_i | cfg_hs;
  assign flush_done_o = (state_q == RoFlushUpdate);
  assign busy_o       = (state_q != RoFlushIdle) | pend_q;

  ro_flush_ack_tracker #(
    .NumCaches(NumCaches)
  ) i_ack_tracker (
    .clk      (clk_i),
    .rst      (rst_i),
    .active   (state_q == RoFlushFlush),
    .clear    (state_q == RoFlushUpdate),
    .ready    (flush_ready_i),
    .valid    (flush_valid),
    .all_acked(all_acked)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      RoFlushIdle: begin
        if (req || pend_q) begin
          state_d = RoFlushFlush;
          pend_d  = 1'b0;
        end
      end
      RoFlushFlush: begin
        if (req) pend_d = 1'b1;
        if (all_acked || timeout_hit) state_d = RoFlushUpdate;
      end
      RoFlushUpdate: begin
        if (req) pend_d = 1'b1;
        state_d = RoFlushIdle;
      end
      default: state_d = RoFlushIdle;
    endcase
  end

  // A cfg accepted in the UPDATE cycle must stay pending, so set wins over clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RoFlushIdle;
      pend_q         <= 1'b0;
      upd_pend_q     <= 1'b0;
      enable_q       <= 1'b0;
      shadow_start_q <= '0;
      shadow_end_q   <= '0;
      start_q        <= '0;
      end_q          <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      enable_q <= enable_i;
      if (cfg_hs) begin
        shadow_start_q <= start_addr_i;
        shadow_end_q   <= end_addr_i;
      end
      if (state_q == RoFlushUpdate && upd_pend_q) begin
        start_q <= shadow_start_q;
        end_q   <= shadow_end_q;
      end
      if (cfg_hs) upd_pend_q <= 1'b1;
      else if (state_q == RoFlushUpdate) upd_pend_q <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumCaches; i++) begin
      ro_cache_ctrl_o[i].enable      = (state_q == RoFlushIdle) & enable_q;
      ro_cache_ctrl_o[i].flush_valid = flush_valid[i];
      ro_cache_ctrl_o[i].start_addr  = start_q;
      ro_cache_ctrl_o[i].end_addr    = end_q;
    end
  end

`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            timeout_q;

  assign timeout_hit = (state_q == RoFlushFlush) && (tmo_cnt_q == CntW'(TimeoutCycles - 1));
  assign timeout_o   = timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == RoFlushFlush) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else tmo_cnt_q <= '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Watchdog limit is only meaningful with the watchdog built in.
  if (TimeoutCycles == 0) begin : g_no_watchdog
  end
`endif

endmodule

// File: tb/tb_ro_cache_flush_ctrl.sv
// Scoreboard bench for ro_cache_flush_ctrl: expected post-sequence rules are
// queued when a sequence is requested and checked after each flush_done pulse.
module tb_ro_cache_flush_ctrl;
  import mempool_pkg::*;

  localparam int unsigned NC  = 4;
  localparam int unsigned NR  = ROCacheNumAddrRules;
  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 16;

  typedef logic [NR-1:0][AW-1:0] rules_t;
  typedef struct {
    rules_t s;
    rules_t e;
    logic   en;
  } exp_t;

  logic clk = 1'b0;
  logic rst, enable, flush_req, cfg_valid, cfg_ready, busy, flush_done;
  rules_t start_addr, end_addr;
  ro_cache_ctrl_t [NC-1:0] ctrl;
  logic [NC-1:0] flush_ready;
`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
  logic timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic chk_next = 1'b0;
  rules_t model_s, model_e, old_s, old_e;

  always #5 clk = ~clk;

  ro_cache_flush_ctrl #(
    .NumCaches    (NC),
    .NrAddrRules  (NR),
    .AddrWidth    (AW),
    .TimeoutCycles(TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .flush_req_i    (flush_req),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .start_addr_i   (start_addr),
    .end_addr_i     (end_addr),
    .busy_o         (busy),
    .flush_done_o   (flush_done),
    .ro_cache_ctrl_o(ctrl),
    .flush_ready_i  (flush_ready)
`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
    ,
    .timeout_o      (timeout)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC-1:0] en_mask();
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = ctrl[i].enable;
    return m;
  endfunction

  function automatic logic [NC-1:0] fv_mask();
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = ctrl[i].flush_valid;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq();
    exp_t item;
    item.s  = model_s;
    item.e  = model_e;
    item.en = enable;
    exp_q.push_back(item);
  endtask

  // Rules and enable are compared the cycle after each flush_done pulse.
  always @(negedge clk) begin
    if (rst) begin
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        chk_next = 1'b0;
        for (int i = 0; i < NC; i++) begin
          for (int r = 0; r < NR; r++) begin
            check_eq($sformatf("sb_start_c%0d_r%0d", i, r), 64'(ctrl[i].start_addr[r]), 64'(cur.s[r]));
            check_eq($sformatf("sb_end_c%0d_r%0d", i, r), 64'(ctrl[i].end_addr[r]), 64'(cur.e[r]));
          end
        end
        check_eq("sb_enable", 64'(en_mask()), 64'({NC{cur.en}}));
      end
      if (flush_done) begin
        done_cnt++;
        check_eq("sb_done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk_next = 1'b1;
        end
      end
    end
  end

  initial begin
    int ack_c[NC] = '{1, 3, 5, 8};
    logic [NC-1:0] exp_fv;
    int d0;

    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; cfg_valid = 1'b0;
    flush_ready = '0; start_addr = '0; end_addr = '0;
    model_s = '0; model_e = '0;
    step(); step();
    check_eq("rst_enable", 64'(en_mask()), 64'd0);
    check_eq("rst_fv", 64'(fv_mask()), 64'd0);
    check_eq("rst_start", 64'(ctrl[0].start_addr), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(flush_done), 64'd0);
    check_eq("rst_cfg_ready", 64'(cfg_ready), 64'd1);
`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
    check_eq("rst_timeout", 64'(timeout), 64'd0);
`endif
    rst = 1'b0; enable = 1'b1;
    step(); step();

    // Basic flush
    flush_ready = '1; flush_req = 1'b1; push_seq();
    step(); flush_req = 1'b0;
    check_eq("basic_c1_enable", 64'(en_mask()), 64'd0);
    check_eq("basic_c1_fv", 64'(fv_mask()), 64'hF);
    check_eq("basic_c1_busy", 64'(busy), 64'd1);
    check_eq("basic_c1_done", 64'(flush_done), 64'd0);
    step();
    check_eq("basic_c2_done", 64'(flush_done), 64'd1);
    check_eq("basic_c2_enable", 64'(en_mask()), 64'd0);
    check_eq("basic_c2_fv", 64'(fv_mask()), 64'd0);
    step();
    check_eq("basic_c3_enable", 64'(en_mask()), 64'hF);
    check_eq("basic_c3_done", 64'(flush_done), 64'd0);
    check_eq("basic_c3_busy", 64'(busy), 64'd0);

    // Staggered acks
    flush_ready = '0; step();
    flush_req = 1'b1; push_seq();
    for (int c = 1; c <= 10; c++) begin
      step(); flush_req = 1'b0;
      for (int i = 0; i < NC; i++) begin
        flush_ready[i] = (c >= ack_c[i]);
        exp_fv[i] = (c <= ack_c[i]);
      end
      check_eq($sformatf("stag_fv_c%0d", c), 64'(fv_mask()), 64'(exp_fv));
      check_eq($sformatf("stag_done_c%0d", c), 64'(flush_done), 64'(c == 9));
    end

    // Rule update
    flush_ready = '1;
    old_s = model_s; old_e = model_e;
    start_addr[0] = 32'h8000_0000; end_addr[0] = 32'h8001_0000;
    start_addr[1] = 32'h9000_0000; end_addr[1] = 32'h9000_1000;
    model_s = start_addr; model_e = end_addr;
    cfg_valid = 1'b1; push_seq();
    step(); cfg_valid = 1'b0;
    check_eq("rule_c1_old_start", 64'(ctrl[0].start_addr), 64'(old_s));
    check_eq("rule_c1_cfg_ready", 64'(cfg_ready), 64'd0);
    step();
    check_eq("rule_c2_done", 64'(flush_done), 64'd1);
    check_eq("rule_c2_old_end", 64'(ctrl[NC-1].end_addr), 64'(old_e));
    step();
    check_eq("rule_c3_new_start", 64'(ctrl[0].start_addr), 64'(model_s));
    check_eq("rule_c3_new_end", 64'(ctrl[NC-1].end_addr), 64'(model_e));
    check_eq("rule_c3_cfg_ready", 64'(cfg_ready), 64'd1);

    // Merge and pend
    flush_ready = '0; flush_req = 1'b1; push_seq(); push_seq(); d0 = done_cnt;
    for (int c = 1; c <= 12; c++) begin
      step();
      flush_req = (c == 2 || c == 4 || c == 5);
      flush_ready = (c >= 7) ? '1 : '0;
      check_eq($sformatf("merge_busy_c%0d", c), 64'(busy), 64'(c <= 11));
    end
    check_eq("merge_done_count", 64'(done_cnt - d0), 64'd2);

    // Reset mid-flush, with a rule update in flight
    flush_ready = '0; d0 = done_cnt;
    start_addr[0] = 32'hA000_0000; end_addr[0] = 32'hA000_8000;
    cfg_valid = 1'b1; flush_req = 1'b1;
    step(); cfg_valid = 1'b0; flush_req = 1'b0; flush_ready = 4'b0011;
    step();
    check_eq("rstmid_fv_before", 64'(fv_mask()), 64'hC);
    rst = 1'b1;
    step();
    model_s = '0; model_e = '0; exp_q.delete();
    check_eq("rstmid_enable", 64'(en_mask()), 64'd0);
    check_eq("rstmid_fv", 64'(fv_mask()), 64'd0);
    check_eq("rstmid_start", 64'(ctrl[0].start_addr), 64'd0);
    check_eq("rstmid_end", 64'(ctrl[NC-1].end_addr), 64'd0);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_done", 64'(flush_done), 64'd0);
    check_eq("rstmid_cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0; flush_ready = '1;
    step();
    flush_req = 1'b1; push_seq();
    step(); flush_req = 1'b0;
    step(); step();
    check_eq("rstmid_shadow_dropped", 64'(ctrl[0].start_addr), 64'd0);
    check_eq("rstmid_done_count", 64'(done_cnt - d0), 64'd1);

`ifdef RO_CACHE_FLUSH_TIMEOUT_EN
    // Watchdog: cache 3 never acknowledges
    start_addr[0] = 32'hB000_0000; end_addr[0] = 32'hB000_4000;
    model_s = start_addr; model_e = end_addr;
    flush_ready = 4'b0111; cfg_valid = 1'b1; flush_req = 1'b1; push_seq();
    for (int c = 1; c <= 20; c++) begin
      step(); cfg_valid = 1'b0; flush_req = 1'b0;
      check_eq($sformatf("tmo_done_c%0d", c), 64'(flush_done), 64'(c == TMO + 1));
      check_eq($sformatf("tmo_flag_c%0d", c), 64'(timeout), 64'(c >= TMO + 1));
    end
`endif

    step(); step();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
